// File: rtl/periph_bus_responder.sv
// periph_bus_responder
//   Memory-mapped peripheral block on the CPU data-memory bus. It decodes a
//   seven-word register window and services CPU loads and stores to a
//   reload timer with interrupt, a free-running systick counter, an LED
//   register and an 8N1 UART transmitter.
//
//   Register map (word offsets from BASE_ADDR):
//     0x00 TH        RW  timer reload value
//     0x04 TL        RW  timer count
//     0x08 TCON      RW  [0]=enable [1]=irq_en [2]=irq_status
//     0x0C LED       RW  [7:0]
//     0x10 SYSTICK   RO  +1 every cycle
//     0x14 UART_TXD  W   [7:0] byte to send; reads return last accepted byte
//     0x18 UART_CON  RO/W1C  [0]=tx_busy [1]=tx_done (write 1 to clear)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   reset       asynchronous, active-high reset
//   MemRead     CPU load strobe
//   MemWrite    CPU store strobe
//   Address     byte address, bits [1:0] ignored
//   Write_data  store data
//   Read_data   load data (combinational, zero unless MemRead & hit)
//   hit         Address lies inside the register window (combinational)
//   irq         timer interrupt request (registered)
//   led         LED register
//   uart_tx     serial output, idle high
module periph_bus_responder #(
    parameter logic [31:0] BASE_ADDR    = 32'h4000_0000,
    parameter int unsigned CLKS_PER_BIT = 10417
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    output logic        hit,
    output logic        irq,
    output logic [7:0]  led,
    output logic        uart_tx
);

    localparam int unsigned CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam int unsigned NUM_REGS = 7;

    localparam logic [2:0] OFF_TH      = 3'd0;
    localparam logic [2:0] OFF_TL      = 3'd1;
    localparam logic [2:0] OFF_TCON    = 3'd2;
    localparam logic [2:0] OFF_LED     = 3'd3;
    localparam logic [2:0] OFF_SYSTICK = 3'd4;
    localparam logic [2:0] OFF_TXD     = 3'd5;
    localparam logic [2:0] OFF_UCON    = 3'd6;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    // ------------------------------------------------------------------
    // Address decode: word offset relative to the base, window is 7 words
    // ------------------------------------------------------------------
    logic [29:0] word_off_c;
    logic [2:0]  reg_sel_c;
    logic        wr_c;
    logic        wr_th_c, wr_tl_c, wr_tcon_c, wr_led_c, wr_txd_c, wr_ucon_c;
    logic        unused_addr_c;

    assign word_off_c    = Address[31:2] - BASE_ADDR[31:2];
    assign hit           = (word_off_c < 30'(NUM_REGS));
    assign reg_sel_c     = word_off_c[2:0];
    assign unused_addr_c = ^Address[1:0];

    assign wr_c      = MemWrite & hit;
    assign wr_th_c   = wr_c & (reg_sel_c == OFF_TH);
    assign wr_tl_c   = wr_c & (reg_sel_c == OFF_TL);
    assign wr_tcon_c = wr_c & (reg_sel_c == OFF_TCON);
    assign wr_led_c  = wr_c & (reg_sel_c == OFF_LED);
    assign wr_txd_c  = wr_c & (reg_sel_c == OFF_TXD);
    assign wr_ucon_c = wr_c & (reg_sel_c == OFF_UCON);

    // ------------------------------------------------------------------
    // Register state
    // ------------------------------------------------------------------
    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic        tcon_en_q, tcon_en_d;
    logic        tcon_ie_q, tcon_ie_d;
    logic        tcon_st_q, tcon_st_d;
    logic        irq_q, irq_d;
    logic [7:0]  led_q, led_d;
    logic [31:0] tick_q, tick_d;

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       txd_q, txd_d;
    logic             done_q, done_d;
    logic             tx_q, tx_d;
    logic             tx_busy_c;
    logic             timer_ovf_c;
    logic             cnt_wrap_c;

    assign tx_busy_c = (state_q != UART_IDLE);

    // Timer, LED and systick next-state; a CPU write to TL beats the count
    // and a TCON write never drops an overflow that happens in the same cycle
    always_comb begin
        th_d      = th_q;
        tl_d      = tl_q;
        tcon_en_d = tcon_en_q;
        tcon_ie_d = tcon_ie_q;
        tcon_st_d = tcon_st_q;
        led_d     = led_q;
        tick_d    = tick_q + 32'd1;
        irq_d     = tcon_ie_q & tcon_st_q;

        timer_ovf_c = tcon_en_q & (tl_q == 32'hFFFF_FFFF);

        if (wr_th_c) begin
            th_d = Write_data;
        end

        if (wr_tl_c) begin
            tl_d = Write_data;
        end else if (tcon_en_q) begin
            tl_d = timer_ovf_c ? th_q : (tl_q + 32'd1);
        end

        if (wr_tcon_c) begin
            tcon_en_d = Write_data[0];
            tcon_ie_d = Write_data[1];
            tcon_st_d = Write_data[2] | (timer_ovf_c & Write_data[1]);
        end else if (timer_ovf_c & tcon_ie_q) begin
            tcon_st_d = 1'b1;
        end

        if (wr_led_c) begin
            led_d = Write_data[7:0];
        end
    end

    // UART transmitter next-state and line value
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        txd_d   = txd_q;
        done_d  = done_q;
        tx_d    = 1'b1;

        cnt_wrap_c = (cnt_q == CNT_LAST);

        // Clear first so a completion in the same cycle re-sets tx_done
        if (wr_ucon_c && Write_data[1]) begin
            done_d = 1'b0;
        end

        case (state_q)
            UART_IDLE: begin
                if (wr_txd_c) begin
                    txd_d   = Write_data[7:0];
                    state_d = UART_START;
                    cnt_d   = '0;
                    bit_d   = 3'd0;
                end
            end
            UART_START: begin
                if (cnt_wrap_c) begin
                    cnt_d   = '0;
                    state_d = UART_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_DATA: begin
                if (cnt_wrap_c) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = UART_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            UART_STOP: begin
                if (cnt_wrap_c) begin
                    cnt_d   = '0;
                    state_d = UART_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = UART_IDLE;
                cnt_d   = '0;
                bit_d   = 3'd0;
            end
        endcase

        // Line level follows the state being entered so uart_tx is a flop
        case (state_d)
            UART_START: tx_d = 1'b0;
            UART_DATA:  tx_d = txd_d[bit_d];
            default:    tx_d = 1'b1;
        endcase
    end

    // Timer / LED / systick registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_en_q <= 1'b0;
            tcon_ie_q <= 1'b0;
            tcon_st_q <= 1'b0;
            irq_q     <= 1'b0;
            led_q     <= '0;
            tick_q    <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_en_q <= tcon_en_d;
            tcon_ie_q <= tcon_ie_d;
            tcon_st_q <= tcon_st_d;
            irq_q     <= irq_d;
            led_q     <= led_d;
            tick_q    <= tick_d;
        end
    end

    // UART state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= UART_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            txd_q   <= '0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            txd_q   <= txd_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    // Load data mux, no read side effects
    always_comb begin
        Read_data = 32'h0;
        if (MemRead && hit) begin
            case (reg_sel_c)
                OFF_TH:      Read_data = th_q;
                OFF_TL:      Read_data = tl_q;
                OFF_TCON:    Read_data = {29'd0, tcon_st_q, tcon_ie_q, tcon_en_q};
                OFF_LED:     Read_data = {24'd0, led_q};
                OFF_SYSTICK: Read_data = tick_q;
                OFF_TXD:     Read_data = {24'd0, txd_q};
                OFF_UCON:    Read_data = {30'd0, done_q, tx_busy_c};
                default:     Read_data = 32'h0;
            endcase
        end
    end

    assign irq     = irq_q;
    assign led     = led_q;
    assign uart_tx = tx_q;

endmodule

// File: tb/tb_periph_bus_responder.sv
// Bench for periph_bus_responder: directed scenarios plus random bus traffic,
// every cycle compared against a register-level model of the peripheral.
module tb_periph_bus_responder;

    localparam int unsigned CPB  = 4;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk;
    logic        reset;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic [31:0] Read_data;
    logic        hit;
    logic        irq;
    logic [7:0]  led;
    logic        uart_tx;

    periph_bus_responder #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Address    (Address),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .hit        (hit),
        .irq        (irq),
        .led        (led),
        .uart_tx    (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_th, m_tl, m_tick, m_ntl, m_off;
    logic        m_en, m_ie, m_st, m_irq, m_ovf, m_w, m_busy_old;
    logic [7:0]  m_led, m_txd;
    logic        m_busy, m_done;
    int unsigned m_cyc, m_start;

    function automatic logic in_window(input logic [31:0] a);
        return (a - BASE) < 32'h1C;
    endfunction

    function automatic logic [31:0] model_read(input logic rd, input logic [31:0] a);
        if (!rd || !in_window(a)) return 32'h0;
        case ((a - BASE) >> 2)
            0: return m_th;
            1: return m_tl;
            2: return {29'd0, m_st, m_ie, m_en};
            3: return {24'd0, m_led};
            4: return m_tick;
            5: return {24'd0, m_txd};
            6: return {30'd0, m_done, m_busy};
            default: return 32'h0;
        endcase
    endfunction

    // Serial frame = start(0), 8 data bits LSB first, stop(1), CPB cycles each
    function automatic logic model_tx();
        logic [9:0]  frame;
        int unsigned k;
        if (!m_busy) return 1'b1;
        frame = {1'b1, m_txd, 1'b0};
        k = (m_cyc - m_start) / CPB;
        if (k > 9) return 1'b1;
        return frame[k];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_th = 0; m_tl = 0; m_tick = 0;
            m_en = 0; m_ie = 0; m_st = 0; m_irq = 0;
            m_led = 0; m_txd = 0; m_busy = 0; m_done = 0;
            m_cyc = 0; m_start = 0;
        end else begin
            m_w   = MemWrite && in_window(Address);
            m_off = (Address - BASE) >> 2;
            m_ovf = m_en && (m_tl == 32'hFFFF_FFFF);
            m_irq = m_ie & m_st;
            m_ntl = m_tl;
            if (m_w && m_off == 1) m_ntl = Write_data;
            else if (m_en) m_ntl = m_ovf ? m_th : m_tl + 1;
            if (m_w && m_off == 2) begin
                m_st = Write_data[2] | (m_ovf & Write_data[1]);
                m_en = Write_data[0];
                m_ie = Write_data[1];
            end else if (m_ovf && m_ie) begin
                m_st = 1'b1;
            end
            m_tl = m_ntl;
            if (m_w && m_off == 0) m_th = Write_data;
            if (m_w && m_off == 3) m_led = Write_data[7:0];
            m_tick = m_tick + 1;
            m_cyc  = m_cyc + 1;
            m_busy_old = m_busy;
            if (m_w && m_off == 6 && Write_data[1]) m_done = 1'b0;
            if (m_busy_old && (m_cyc - m_start == 10 * CPB)) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            if (!m_busy_old && m_w && m_off == 5) begin
                m_txd   = Write_data[7:0];
                m_busy  = 1'b1;
                m_start = m_cyc;
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("hit", 32'(hit), 32'(in_window(Address)));
        chk("read_data", Read_data, model_read(MemRead, Address));
        chk("irq", 32'(irq), 32'(m_irq));
        chk("led", 32'(led), 32'(m_led));
        chk("uart_tx", 32'(uart_tx), 32'(model_tx()));
    end

    // ---------------- stimulus helpers ----------------
    task automatic bus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead = rd; MemWrite = wr; Address = a; Write_data = d;
        @(posedge clk); #1;
    endtask

    task automatic wr_reg(input logic [31:0] off, input logic [31:0] d);
        bus(1'b0, 1'b1, BASE + off, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            bus(1'b1, 1'b0, BASE + (32'($urandom_range(0, 8)) << 2), $urandom);
    endtask

    task automatic rd_expect(input logic [31:0] off, input logic [31:0] exp, input string name);
        MemRead = 1'b1; MemWrite = 1'b0; Address = BASE + off;
        @(negedge clk);
        chk(name, Read_data, exp);
        @(posedge clk); #1;
    endtask

    task automatic hit_expect(input logic [31:0] a, input logic exp);
        MemRead = 1'b0; MemWrite = 1'b0; Address = a;
        @(negedge clk);
        chk("hit_decode", 32'(hit), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [9:0]  ef;
        logic [31:0] v1, v2, a, d;
        logic        found;
        int          r;

        MemRead = 0; MemWrite = 0; Address = 0; Write_data = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: reset values and decode
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_irq", 32'(irq), 32'd0);
        rd_expect(32'h00, 32'h0, "rst_th");
        rd_expect(32'h04, 32'h0, "rst_tl");
        rd_expect(32'h08, 32'h0, "rst_tcon");
        rd_expect(32'h0C, 32'h0, "rst_led");
        rd_expect(32'h14, 32'h0, "rst_txd");
        rd_expect(32'h18, 32'h0, "rst_ucon");
        for (int i = 0; i < 7; i++) hit_expect(BASE + 32'(i * 4), 1'b1);
        hit_expect(32'h4000_001B, 1'b1);
        hit_expect(32'h4000_001C, 1'b0);
        hit_expect(32'h4000_0020, 1'b0);
        hit_expect(32'h3FFF_FFFC, 1'b0);
        hit_expect(32'h1000_0000, 1'b0);

        // 2: timer overflow, reload and irq timing
        wr_reg(32'h00, 32'hFFFF_FFF0);
        wr_reg(32'h04, 32'hFFFF_FFFE);
        wr_reg(32'h08, 32'h3);
        rd_expect(32'h04, 32'hFFFF_FFFE, "tl_before_inc");
        rd_expect(32'h04, 32'hFFFF_FFFF, "tl_max");
        chk("irq_not_yet", 32'(irq), 32'd0);
        rd_expect(32'h08, 32'h7, "tcon_status_set");
        chk("irq_asserted", 32'(irq), 32'd1);
        wr_reg(32'h08, 32'h3);
        chk("irq_one_cycle_lag", 32'(irq), 32'd1);
        idle(1);
        chk("irq_cleared", 32'(irq), 32'd0);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            idle(1);
            if (irq) found = 1'b1;
        end
        chk("irq_reassert", 32'(found), 32'd1);
        wr_reg(32'h08, 32'h0);

        // 3: UART frame 0xA5, mid-frame write ignored
        ef = {1'b1, 8'hA5, 1'b0};
        wr_reg(32'h14, 32'hA5);
        for (int k = 0; k < 10; k++) begin
            chk("uart_bit", 32'(uart_tx), 32'(ef[k]));
            if (k == 3) begin
                wr_reg(32'h14, 32'h3C);
                idle(3);
            end else if (k == 5) begin
                rd_expect(32'h18, 32'h1, "ucon_busy");
                idle(3);
            end else begin
                idle(4);
            end
        end
        rd_expect(32'h18, 32'h2, "ucon_done");
        rd_expect(32'h14, 32'hA5, "txd_latched");
        wr_reg(32'h18, 32'h2);
        rd_expect(32'h18, 32'h0, "ucon_w1c");
        // W1C in the completion cycle loses to the set
        wr_reg(32'h14, 32'h81);
        idle(10 * CPB - 1);
        wr_reg(32'h18, 32'h2);
        rd_expect(32'h18, 32'h2, "ucon_set_wins");
        wr_reg(32'h18, 32'h2);

        // 4: collisions
        wr_reg(32'h00, 32'h100);
        wr_reg(32'h04, 32'hFFFF_FFFF);
        wr_reg(32'h08, 32'h3);
        wr_reg(32'h08, 32'h3);
        rd_expect(32'h08, 32'h7, "tcon_clear_loses");
        rd_expect(32'h04, 32'h101, "tl_after_reload");
        wr_reg(32'h04, 32'h55);
        rd_expect(32'h04, 32'h55, "tl_write_wins");
        rd_expect(32'h04, 32'h56, "tl_resumes");
        wr_reg(32'h08, 32'h0);

        // 5: systick delta, LED width, out-of-window store
        MemRead = 1; MemWrite = 0; Address = BASE + 32'h10;
        @(negedge clk); v1 = Read_data;
        @(posedge clk); #1;
        idle(36);
        MemRead = 1; MemWrite = 0; Address = BASE + 32'h10;
        @(negedge clk); v2 = Read_data;
        @(posedge clk); #1;
        chk("systick_delta", v2 - v1, 32'd37);
        wr_reg(32'h0C, 32'h1FF);
        chk("led_pins", 32'(led), 32'hFF);
        rd_expect(32'h0C, 32'hFF, "led_read");
        bus(1'b0, 1'b1, BASE + 32'h20, 32'hDEAD_BEEF);
        rd_expect(32'h0C, 32'hFF, "led_unmapped");
        rd_expect(32'h00, 32'h100, "th_unmapped");

        // Random traffic, checked every cycle by the model
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 9);
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 6)) : $urandom;
            if (r < 3) begin
                wr_reg(32'($urandom_range(0, 6)) << 2, d);
            end else if (r == 3) begin
                a = ($urandom_range(0, 1) == 0) ? BASE + 32'h1C + (32'($urandom_range(0, 3)) << 2)
                                                : 32'h1000_0000 + (32'($urandom_range(0, 6)) << 2);
                bus(1'b0, 1'b1, a, d);
            end else begin
                idle(1);
            end
        end

        // 6: reset in the middle of a frame
        for (int i = 0; i < 200 && m_busy; i++) idle(1);
        chk("uart_quiet", 32'(m_busy), 32'd0);
        wr_reg(32'h0C, 32'h5A);
        wr_reg(32'h14, 32'h5A);
        idle(4 * 3 + 1);
        #2 reset = 1'b1;
        #1 chk("uart_async_reset", 32'(uart_tx), 32'd1);
        @(posedge clk); #1 reset = 1'b0;
        rd_expect(32'h18, 32'h0, "post_rst_ucon");
        rd_expect(32'h04, 32'h0, "post_rst_tl");
        rd_expect(32'h00, 32'h0, "post_rst_th");
        rd_expect(32'h0C, 32'h0, "post_rst_led");
        rd_expect(32'h14, 32'h0, "post_rst_txd");
        chk("post_rst_led_pins", 32'(led), 32'd0);
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
